ref_sched: RTL and testbench

Refresh scheduler for the DRAM controller. Divides CLK down to the per-row refresh interval, keeps a saturating count of owed refreshes, and drives the controller's `RefReqIn`/`RefUrgIn` inputs. Re-arms the controller's internal refresh-done latch by holding both outputs low for a fixed window after each refresh starts. Sits beside the RAM controller in the CPLD and is its only source of refresh demand.

---
 rtl/ram_ctl_pkg.sv | 14 +
 rtl/ref_sched_if.sv | 18 +
 rtl/ref_divider.sv | 34 +++
 rtl/ref_sched.sv | 87 ++++++++
 tb/tb_ref_sched.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/ram_ctl_pkg.sv
// ram_ctl_pkg: default parameters and widths shared by the RAM controller blocks.
// Revision: 1.0
`default_nettype none

package ram_ctl_pkg;
   localparam int REF_DIV_DEFAULT    = 390;
   localparam int DEBT_MAX_DEFAULT   = 4;
   localparam int URG_THRESH_DEFAULT = 2;
   localparam int HOLD_DEFAULT       = 4;
   localparam int DIV_W              = 9;
   localparam int DEBT_W             = 3;
endpackage

`default_nettype wire

// File: rtl/ref_sched_if.sv
// ref_sched_if: refresh handshake between ref_sched and the DRAM controller.
// Revision: 1.0
`default_nettype none

interface ref_sched_if;
   logic RefStart;
   logic RefInhibit;
   logic RefReq;
   logic RefUrg;
   logic Overrun;

   modport master (output RefStart, output RefInhibit,
                   input  RefReq,   input  RefUrg,   input Overrun);
   modport slave  (input  RefStart, input  RefInhibit,
                   output RefReq,   output RefUrg,   output Overrun);
endinterface

`default_nettype wire

// File: rtl/ref_divider.sv
// ref_divider: free-running prescaler, o_tick high in the last cycle of each slot.
// Revision: 1.0
`default_nettype none

module ref_divider
   import ram_ctl_pkg::*;
#(
   parameter int REF_DIV = REF_DIV_DEFAULT
)(
   input  logic CLK,
   input  logic nRST,
   output logic o_tick
);

   localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(REF_DIV - 1);

   logic [DIV_W-1:0] r_div;
   logic             w_tick;

   assign w_tick = (r_div == C_DIV_LAST);
   assign o_tick = w_tick;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         r_div <= '0;
      else if (w_tick)
         r_div <= '0;
      else
         r_div <= r_div + 1'b1;
   end

endmodule

`default_nettype wire

// File: rtl/ref_sched.sv
// ref_sched: refresh debt tracker and request/urgent generator with post-refresh hold.
// Revision: 1.0
`default_nettype none

module ref_sched
   import ram_ctl_pkg::*;
#(
   parameter int REF_DIV    = REF_DIV_DEFAULT,
   parameter int DEBT_MAX   = DEBT_MAX_DEFAULT,
   parameter int URG_THRESH = URG_THRESH_DEFAULT,
   parameter int HOLD       = HOLD_DEFAULT
)(
   input  logic        CLK,
   input  logic        nRST,
   ref_sched_if.slave  bus
);

   localparam int                HC_W         = $clog2(HOLD + 1);
   localparam logic [DEBT_W-1:0] C_DEBT_MAX   = DEBT_W'(DEBT_MAX);
   localparam logic [DEBT_W-1:0] C_URG_THRESH = DEBT_W'(URG_THRESH);
   localparam logic [HC_W-1:0]   C_HOLD       = HC_W'(HOLD);

   logic              w_tick;
   logic [DEBT_W-1:0] r_debt;
   logic [DEBT_W-1:0] w_debt_nxt;
   logic [HC_W-1:0]   r_hc;
   logic [HC_W-1:0]   w_hc_nxt;
   logic              w_ovr_set;
   logic              w_open;
   logic              r_req;
   logic              r_urg;
   logic              r_ovr;

   ref_divider #(.REF_DIV(REF_DIV)) u_div (
      .CLK    (CLK),
      .nRST   (nRST),
      .o_tick (w_tick)
   );

   // A tick and a refresh start in the same cycle cancel out entirely.
   always_comb begin
      w_debt_nxt = r_debt;
      w_ovr_set  = 1'b0;
      if (w_tick && !bus.RefStart) begin
         if (r_debt == C_DEBT_MAX)
            w_ovr_set = 1'b1;
         else
            w_debt_nxt = r_debt + 1'b1;
      end else if (bus.RefStart && !w_tick) begin
         if (r_debt != '0)
            w_debt_nxt = r_debt - 1'b1;
      end
   end

   always_comb begin
      w_hc_nxt = r_hc;
      if (bus.RefStart)
         w_hc_nxt = C_HOLD;
      else if (r_hc != '0)
         w_hc_nxt = r_hc - 1'b1;
   end

   assign w_open = (w_hc_nxt == '0) && !bus.RefInhibit;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_debt <= '0;
         r_hc   <= '0;
         r_req  <= 1'b0;
         r_urg  <= 1'b0;
         r_ovr  <= 1'b0;
      end else begin
         r_debt <= w_debt_nxt;
         r_hc   <= w_hc_nxt;
         r_req  <= w_open && (w_debt_nxt != '0);
         r_urg  <= w_open && (w_debt_nxt >= C_URG_THRESH);
         r_ovr  <= r_ovr | w_ovr_set;
      end
   end

   assign bus.RefReq  = r_req;
   assign bus.RefUrg  = r_urg;
   assign bus.Overrun = r_ovr;

endmodule

`default_nettype wire

// File: tb/tb_ref_sched.sv
// tb_ref_sched: directed checks of ref_sched with default parameters (REF_DIV=390).
// Revision: 1.0
`default_nettype none

module tb_ref_sched;
   logic CLK;
   logic nRST;
   int   n_vec;
   int   n_err;
   int   cyc;

   ref_sched_if bus();

   ref_sched dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic req, input logic urg);
      chk({tag, ".req"}, 32'(bus.RefReq), 32'(req));
      chk({tag, ".urg"}, 32'(bus.RefUrg), 32'(urg));
   endtask

   // Cycle k is sampled on the negedge following the k-th posedge after release.
   task automatic run_to(input int c);
      while (cyc < c) begin
         @(negedge CLK);
         cyc++;
      end
   endtask

   task automatic pulse_start();
      bus.RefStart = 1'b1;
      run_to(cyc + 1);
      bus.RefStart = 1'b0;
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      #1;
      @(negedge CLK);
      nRST = 1'b1;
      cyc  = 0;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      cyc   = 0;
      bus.RefStart   = 1'b0;
      bus.RefInhibit = 1'b0;
      nRST = 1'b0;
      repeat (2) @(negedge CLK);
      nRST = 1'b1;

      // Phase 1: first ticks, then refresh handshakes.
      chk_out("rst", 1'b0, 1'b0);
      chk("rst.ovr", 32'(bus.Overrun), 32'd0);
      run_to(389);  chk_out("c389", 1'b0, 1'b0);
      run_to(390);  chk_out("c390", 1'b1, 1'b0);
      run_to(779);  chk_out("c779", 1'b1, 1'b0);
      run_to(780);  chk_out("c780", 1'b1, 1'b1);
      run_to(1170); chk("d3.debt", 32'(dut.r_debt), 32'd3);
      pulse_start();
      for (int c = 1171; c <= 1174; c++) begin
         run_to(c); chk_out("d3.hold", 1'b0, 1'b0);
      end
      run_to(1175); chk_out("d3.open", 1'b1, 1'b1);
      chk("d3.debt2", 32'(dut.r_debt), 32'd2);
      pulse_start();
      run_to(1180); chk_out("d2.open", 1'b1, 1'b0);
      pulse_start();
      for (int c = 1181; c <= 1184; c++) begin
         run_to(c); chk_out("d1.hold", 1'b0, 1'b0);
      end
      run_to(1190); chk_out("d1.after", 1'b0, 1'b0);
      chk("d1.debt0", 32'(dut.r_debt), 32'd0);

      // Reset in the middle of a hold window with debt 2.
      run_to(2340); chk("mid.debt3", 32'(dut.r_debt), 32'd3);
      pulse_start();
      run_to(2342);
      chk_out("mid.hold", 1'b0, 1'b0);
      chk("mid.debt2", 32'(dut.r_debt), 32'd2);
      nRST = 1'b0;
      #1;
      chk("ar.debt", 32'(dut.r_debt), 32'd0);
      chk("ar.hc", 32'(dut.r_hc), 32'd0);
      chk("ar.div", 32'(dut.u_div.r_div), 32'd0);
      chk_out("ar", 1'b0, 1'b0);
      chk("ar.ovr", 32'(bus.Overrun), 32'd0);
      @(negedge CLK);
      nRST = 1'b1;
      cyc  = 0;

      // Phase 2: tick coinciding with a refresh start at full debt.
      run_to(389);  chk_out("p2.c389", 1'b0, 1'b0);
      run_to(390);  chk_out("p2.c390", 1'b1, 1'b0);
      run_to(1949); chk("p2.debt4", 32'(dut.r_debt), 32'd4);
      pulse_start();
      chk("both.debt", 32'(dut.r_debt), 32'd4);
      chk("both.ovr", 32'(bus.Overrun), 32'd0);
      for (int c = 1950; c <= 1953; c++) begin
         run_to(c); chk_out("both.hold", 1'b0, 1'b0);
      end
      run_to(1954); chk_out("both.open", 1'b1, 1'b1);

      // Phase 3: saturation sets the sticky overrun flag.
      do_reset();
      run_to(1949); chk("ovr.pre", 32'(bus.Overrun), 32'd0);
      run_to(1950); chk("ovr.set", 32'(bus.Overrun), 32'd1);
      chk("ovr.debt", 32'(dut.r_debt), 32'd4);
      pulse_start();
      run_to(1960); chk("ovr.sticky", 32'(bus.Overrun), 32'd1);
      chk("ovr.debt3", 32'(dut.r_debt), 32'd3);

      // Phase 4: inhibit masks outputs while debt accumulates.
      do_reset();
      bus.RefInhibit = 1'b1;
      run_to(1170);
      chk_out("inh", 1'b0, 1'b0);
      chk("inh.debt", 32'(dut.r_debt), 32'd3);
      bus.RefInhibit = 1'b0;
      chk_out("inh.same", 1'b0, 1'b0);
      run_to(1171); chk_out("inh.drop", 1'b1, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
